// File: rtl/nor_exerciser_if.sv
// nor_exerciser_if
// Purpose : bundles the control and status signals of the NOR-gate exerciser
//           with the drive/observe connections to the gate under test.
// Signals : start     - request one full truth-table pass
//           y_in      - output of the NOR gate under test
//           a_out     - drive to gate input A
//           b_out     - drive to gate input B
//           busy      - pass in progress
//           done      - one-cycle end-of-pass pulse
//           pass      - last completed pass had zero mismatches
//           err_count - mismatching vectors in current/last pass (0..4)
//           fail_vec  - bit i set when vector {A,B}=i mismatched
// Modports: master - the side that requests passes and closes the loop
//                    through the gate (testbench / system)
//           slave  - the exerciser itself
interface nor_exerciser_if;
    logic       start;
    logic       y_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        output start,
        output y_in,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_vec
    );

    modport slave (
        input  start,
        input  y_in,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_vec
    );
endinterface

// File: rtl/nor_exerciser.sv
// nor_exerciser
// Purpose : walks a 2-input NOR gate through its truth table (00,01,10,11),
//           holds each vector SETTLE_CYCLES cycles, samples the gate output
//           for one cycle and records mismatches. X/Z on y_in is a mismatch.
// Params  : SETTLE_CYCLES - settle time per vector, legal range 1..15
// Ports   : clk - rising-edge clock
//           rst - asynchronous, active-high reset
//           bus - nor_exerciser_if.slave (start, y_in in; a_out, b_out,
//                 busy, done, pass, err_count, fail_vec out; all registered)
module nor_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nor_exerciser_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter value seen in the last settle cycle of a vector.
    localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 32'd1);

    // Expected NOR response for the vector addressed by idx = {A,B}.
    function automatic logic f_nor_expected(input logic [1:0] idx);
        return ~(idx[1] | idx[0]);
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_idx;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;

    logic       w_expected;
    logic       w_mismatch;
    logic [2:0] w_err_next;
    logic [3:0] w_fail_next;
    logic [1:0] w_idx_next;

    // Compare y_in against the expected value; any non-0/1 level falls to default.
    always_comb begin
        w_expected = f_nor_expected(r_idx);
        w_mismatch = 1'b1;
        case (bus.y_in)
            1'b0:    w_mismatch = w_expected;
            1'b1:    w_mismatch = ~w_expected;
            default: w_mismatch = 1'b1;
        endcase
    end

    // Error bookkeeping for the current sample; the count saturates at 4.
    always_comb begin
        w_idx_next  = r_idx + 2'd1;
        w_err_next  = r_err;
        w_fail_next = r_fail;
        if (w_mismatch) begin
            w_fail_next = r_fail | (4'b0001 << r_idx);
            if (r_err < 3'd4) begin
                w_err_next = r_err + 3'd1;
            end else begin
                w_err_next = r_err;
            end
        end else begin
            w_fail_next = r_fail;
            w_err_next  = r_err;
        end
    end

    // Next-state logic of the pass sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_SETTLE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == LP_SETTLE_LAST) begin
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (r_idx == 2'd3) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered outputs; results hold in IDLE until a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 2'd0;
            r_cnt  <= 4'd0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 3'd0;
            r_fail <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_idx  <= 2'd0;
                        r_cnt  <= 4'd0;
                        r_a    <= 1'b0;
                        r_b    <= 1'b0;
                        r_busy <= 1'b1;
                        r_pass <= 1'b0;
                        r_err  <= 3'd0;
                        r_fail <= 4'd0;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                ST_SAMPLE: begin
                    r_err  <= w_err_next;
                    r_fail <= w_fail_next;
                    if (r_idx == 2'd3) begin
                        // Last vector: publish the verdict including this sample.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == 3'd0);
                    end else begin
                        // Next vector goes out on the same edge as the compare.
                        r_idx <= w_idx_next;
                        r_a   <= w_idx_next[1];
                        r_b   <= w_idx_next[0];
                        r_cnt <= 4'd0;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_vec  = r_fail;

endmodule
